ifetch_sequencer: RTL and testbench

IFETCH_SEQUENCER -- requirements
Module: ifetch_sequencer

---
 rtl/ifetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_ifetch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_sequencer
// Brief    : Single-outstanding instruction fetch sequencer with redirect
//            handling, stale-response discard and a saturating discard count.
// Revision : 1.0
// ============================================================================
module ifetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [7:0]  discard_cnt_o
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_req   = 2'd1;
    localparam logic [1:0]  c_st_wait  = 2'd2;
    localparam logic [1:0]  c_st_hold  = 2'd3;
    localparam logic [31:0] c_pc_incr  = 32'd4;
    localparam logic [31:0] c_word_msk = 32'hFFFF_FFFC;
    localparam logic [31:0] c_reset_pc = RESET_PC & c_word_msk;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_kill;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [7:0]  r_discard_cnt;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_req_pc_nxt;
    logic        w_kill_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_instr_pc_nxt;
    logic [7:0]  w_discard_cnt_nxt;

    logic [31:0] w_redirect_pc;
    logic [7:0]  w_discard_inc;

    assign w_redirect_pc = redirect_pc_i & c_word_msk;
    assign w_discard_inc = (r_discard_cnt == 8'hFF) ? r_discard_cnt : r_discard_cnt + 8'd1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= c_st_idle;
            r_pc          <= c_reset_pc;
            r_req_pc      <= 32'h0;
            r_kill        <= 1'b0;
            r_valid       <= 1'b0;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_discard_cnt <= 8'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_req_pc      <= w_req_pc_nxt;
            r_kill        <= w_kill_nxt;
            r_valid       <= w_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_discard_cnt <= w_discard_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_req_pc_nxt      = r_req_pc;
        w_kill_nxt        = r_kill;
        w_valid_nxt       = r_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_discard_cnt_nxt = r_discard_cnt;

        case (r_state)
            c_st_idle: begin
                w_state_nxt = c_st_req;
            end
            c_st_req: begin
                if (mem_gnt_i) begin
                    w_req_pc_nxt = r_pc;
                    w_pc_nxt     = r_pc + c_pc_incr;
                    w_state_nxt  = c_st_wait;
                    // A grant in the redirect cycle still fetches the old path.
                    w_kill_nxt   = redirect_i;
                end
            end
            c_st_wait: begin
                if (mem_rvalid_i) begin
                    if (r_kill || redirect_i) begin
                        w_discard_cnt_nxt = w_discard_inc;
                        w_state_nxt       = c_st_req;
                    end else begin
                        w_instr_nxt    = mem_rdata_i;
                        w_instr_pc_nxt = r_req_pc;
                        w_valid_nxt    = 1'b1;
                        w_state_nxt    = c_st_hold;
                    end
                    w_kill_nxt = 1'b0;
                end else if (redirect_i) begin
                    w_kill_nxt = 1'b1;
                end
            end
            default: begin
                if (redirect_i || !stall_i) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_st_req;
                end
            end
        endcase

        // Redirect overrides any sequential pc advance decided above.
        if (redirect_i) begin
            w_pc_nxt    = w_redirect_pc;
            w_valid_nxt = 1'b0;
        end
    end

    assign mem_req_o     = (r_state == c_st_req);
    assign mem_addr_o    = r_pc;
    assign instr_valid_o = r_valid;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;
    assign discard_cnt_o = r_discard_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_sequencer
// Brief    : Directed and randomized self-checking bench for ifetch_sequencer
//            against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_ifetch_sequencer;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [7:0]  discard_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: fetch progress tracked as transaction flags, not states.
    logic        m_started;
    logic        m_outstanding;
    logic        m_stale;
    logic        m_have;
    logic [31:0] m_pc;
    logic [31:0] m_out_addr;
    logic [31:0] m_instr;
    logic [31:0] m_instr_pc;
    int          m_discards;

    ifetch_sequencer #(.RESET_PC(c_reset_pc)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .discard_cnt_o (discard_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started     = 1'b0;
        m_outstanding = 1'b0;
        m_stale       = 1'b0;
        m_have        = 1'b0;
        m_pc          = c_reset_pc;
        m_out_addr    = 32'h0;
        m_instr       = 32'h0;
        m_instr_pc    = 32'h0;
        m_discards    = 0;
    endtask

    function automatic logic [7:0] exp_cnt();
        return (m_discards > 255) ? 8'hFF : 8'(m_discards);
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_req"},   {31'h0, mem_req_o},     32'h0);
        chk({tag, "_addr"},  mem_addr_o,             c_reset_pc);
        chk({tag, "_valid"}, {31'h0, instr_valid_o}, 32'h0);
        chk({tag, "_instr"}, instr_o,                32'h0);
        chk({tag, "_ipc"},   instr_pc_o,             32'h0);
        chk({tag, "_cnt"},   {24'h0, discard_cnt_o}, 32'h0);
    endtask

    task automatic check_outputs();
        logic m_req;
        m_req = m_started && !m_outstanding && !m_have;
        chk("mem_req", {31'h0, mem_req_o}, {31'h0, m_req});
        if (m_req) chk("mem_addr", mem_addr_o, m_pc);
        chk("addr_lsb", {30'h0, mem_addr_o[1:0]}, 32'h0);
        chk("instr_valid", {31'h0, instr_valid_o}, {31'h0, m_have});
        if (m_have) begin
            chk("instr", instr_o, m_instr);
            chk("instr_pc", instr_pc_o, m_instr_pc);
        end
        chk("discard_cnt", {24'h0, discard_cnt_o}, {24'h0, exp_cnt()});
    endtask

    task automatic model_edge(input logic rd, input logic [31:0] tgt, input logic st,
                              input logic gnt, input logic rv, input logic [31:0] data);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_outstanding && !m_have) begin
            if (gnt) begin
                m_outstanding = 1'b1;
                m_out_addr    = m_pc;
                m_stale       = rd;
                m_pc          = m_pc + 32'd4;
            end
        end else if (m_outstanding) begin
            if (rv) begin
                m_outstanding = 1'b0;
                if (m_stale || rd) m_discards++;
                else begin
                    m_have     = 1'b1;
                    m_instr    = data;
                    m_instr_pc = m_out_addr;
                end
                m_stale = 1'b0;
            end else if (rd) begin
                m_stale = 1'b1;
            end
        end else begin
            if (rd || !st) m_have = 1'b0;
        end
        if (rd) begin
            m_pc   = t;
            m_have = 1'b0;
        end
    endtask

    task automatic step(input logic rd, input logic [31:0] tgt, input logic st,
                        input logic gnt, input logic rv, input logic [31:0] data);
        redirect_i    = rd;
        redirect_pc_i = tgt;
        stall_i       = st;
        mem_gnt_i     = gnt;
        mem_rvalid_i  = rv;
        mem_rdata_i   = data;
        @(negedge clk_i);
        check_outputs();
        @(posedge clk_i);
        model_edge(rd, tgt, st, gnt, rv, data);
        #1;
    endtask

    initial begin
        rstn_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        stall_i       = 1'b0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_zero_outputs("reset");
        rstn_i = 1'b1;

        // Zero-wait streaming: addresses 0,4,8 with an instruction every 3rd cycle.
        for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0013);

        // Held instruction at 0x8 stays put under stall.
        chk("hold_pc8", instr_pc_o, 32'h8);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        chk("hold_instr", instr_o, 32'h0000_0013);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("after_hold_addr", mem_addr_o, 32'hC);

        // Redirect while waiting; the response arrives two cycles later.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0000_0102, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("kill_cnt1", {24'h0, discard_cnt_o}, 32'h1);
        chk("kill_addr", mem_addr_o, 32'h100);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        chk("kill_next_pc", instr_pc_o, 32'h100);

        // Redirect coincident with grant, then redirect with stall in hold.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0010);
        chk("gnt_kill_addr", mem_addr_o, 32'h40);
        chk("gnt_kill_cnt", {24'h0, discard_cnt_o}, 32'h2);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h5555_0040);
        step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("hold_redir_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("hold_redir_addr", mem_addr_o, 32'h40);

        // Address wrap at the top of the space.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0013);
        chk("wrap_ipc", instr_pc_o, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", mem_addr_o, 32'h0);

        // Saturate the discard counter.
        for (int i = 0; i < 260; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, $urandom);
        end
        chk("cnt_sat", {24'h0, discard_cnt_o}, 32'hFF);

        // Randomized traffic, including spurious grant/rvalid.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(7) == 0), $urandom, 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom);
        end

        // Reach WAIT, then assert reset asynchronously between edges.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("pre_reset_wait", {31'h0, mem_req_o}, 32'h0);
        #2;
        rstn_i = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(posedge clk_i);
        #1;
        check_zero_outputs("rst_held");
        rstn_i = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0);
        chk("post_rst_req", {31'h0, mem_req_o}, 32'h1);
        chk("post_rst_addr", mem_addr_o, c_reset_pc);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'($urandom), 1'($urandom), $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
